// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and highest-index match select
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int hi_sel(input logic [3:0] m);
    int s;
    s = -1;
    for (int j = 0; j < 4; j++) if (m[j]) s = j;
    return s;
  endfunction
endpackage

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: read ports (raddr/rdata/rpend), write ports (wen/waddr/wdata), alloc and scoreboard status
interface regfile_mp_sb_if import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 1
) ();
  localparam int AW = clog2(NREGS);
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0] rpend;
  logic [NWR-1:0] wen;
  logic [NWR*AW-1:0] waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic alloc_en;
  logic [AW-1:0] alloc_addr;
  logic [AW:0] pend_cnt;
  logic sb_idle;
  modport master (
    output raddr, wen, waddr, wdata, alloc_en, alloc_addr,
    input rdata, rpend, pend_cnt, sb_idle
  );
  modport slave (
    input raddr, wen, waddr, wdata, alloc_en, alloc_addr,
    output rdata, rpend, pend_cnt, sb_idle
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending bits (alloc sets, writeback clears, set wins), rpend, registered pend_cnt/sb_idle
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int AW = 5,
  parameter bit ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic [NREGS-1:0]  clr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rpend,
  output logic [AW:0]       pend_cnt,
  output logic              sb_idle
);
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0] cnt_q, cnt_d;
  logic idle_q, idle_d;
  always_comb begin
    for (int r = 0; r < NREGS; r++)
      pend_d[r] = (alloc_en && alloc_addr == AW'(r) && !(ZERO_REG && r == 0)) || (pend_q[r] && !clr[r]);
    cnt_d = (AW+1)'($countones(pend_d));
    idle_d = cnt_d == '0;
  end
  always_comb begin
    rpend = '0;
    for (int i = 0; i < NRD; i++)
      rpend[i] = pend_q[raddr[i*AW +: AW]] && !clr[raddr[i*AW +: AW]];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend_q <= '0;
      cnt_q <= '0;
      idle_q <= 1'b1;
    end else begin
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      idle_q <= idle_d;
    end
  assign pend_cnt = cnt_q;
  assign sb_idle = idle_q;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write-through bypass and pending-write scoreboard; clk, active-low async reset, bus
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter bit ZERO_REG = 1
) (
  input logic clk,
  input logic reset,
  regfile_mp_sb_if.slave bus
);
  localparam int AW = clog2(NREGS);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] clr;
  always_comb begin
    logic [3:0] m;
    int s;
    m = '0;
    s = -1;
    for (int r = 0; r < NREGS; r++) begin
      m = '0;
      for (int j = 0; j < NWR; j++)
        m[j] = bus.wen[j] && bus.waddr[j*AW +: AW] == AW'(r);
      m = (ZERO_REG && r == 0) ? '0 : m;
      s = hi_sel(m);
      clr[r] = |m;
      regs_d[r] = s < 0 ? regs_q[r] : bus.wdata[s*XLEN +: XLEN];
    end
  end
  always_comb begin
    logic [3:0] m;
    logic [AW-1:0] a;
    int s;
    m = '0;
    a = '0;
    s = -1;
    bus.rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      a = bus.raddr[i*AW +: AW];
      m = '0;
      for (int j = 0; j < NWR; j++)
        m[j] = bus.wen[j] && bus.waddr[j*AW +: AW] == a;
      s = hi_sel(m);
      bus.rdata[i*XLEN +: XLEN] = (ZERO_REG && a == '0) ? '0 : s < 0 ? regs_q[a] : bus.wdata[s*XLEN +: XLEN];
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .AW(AW), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .reset(reset),
    .alloc_en(bus.alloc_en),
    .alloc_addr(bus.alloc_addr),
    .clr(clr),
    .raddr(bus.raddr),
    .rpend(bus.rpend),
    .pend_cnt(bus.pend_cnt),
    .sb_idle(bus.sb_idle)
  );
endmodule
